// File: rtl/bram_dump_pkg.sv
// Shared types and constants for the BRAM readback streamer.
package bram_dump_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StIssue = 3'd1,
    StWait  = 3'd2,
    StOut   = 3'd3,
    StFin   = 3'd4
  } dump_state_e;

endpackage

// File: rtl/bram_dump.sv
// Walks a word range through the bram32 debug read port and streams each word,
// tagged with its byte address, on a valid/ready interface. One word in flight.
module bram_dump
  import bram_dump_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 9,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [CNT_WIDTH-1:0]  word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] debug_addr,
  input  logic [DATA_WIDTH-1:0] debug_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned SumW = ADDR_WIDTH + CNT_WIDTH + 2;
  localparam logic [SumW-1:0] MemBytes = SumW'(1) << ADDR_WIDTH;
  localparam logic [1:0] LatInit = (RD_LATENCY > 0) ? 2'(RD_LATENCY - 1) : 2'd0;

  // Widened so a range ending past the top of memory cannot wrap back into range.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a,
                                    input logic [CNT_WIDTH-1:0]  n);
    logic [SumW-1:0] end_addr;
    end_addr = SumW'(a) + SumW'(n) * SumW'(WORD_BYTES);
    return end_addr <= MemBytes;
  endfunction

  dump_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q;
  logic [CNT_WIDTH-1:0]  remaining_q;
  logic [1:0]            lat_cnt_q;
  logic [ADDR_WIDTH-1:0] dbg_addr_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic [ADDR_WIDTH-1:0] m_addr_q;
  logic                  m_last_q;
  logic                  err_q;
  logic                  start_bad;
  logic                  beat_hs;
  logic                  capture;

  assign start_bad = (start_addr[1:0] != 2'b00) || !in_range(start_addr, word_count);
  assign beat_hs   = (state_q == StOut) && m_ready;
  assign capture   = ((state_q == StIssue) && (RD_LATENCY == 0)) ||
                     ((state_q == StWait) && (lat_cnt_q == 2'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_bad || (word_count == '0)) begin
            state_d = StFin;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (abort) begin
          state_d = StFin;
        end else if (RD_LATENCY == 0) begin
          state_d = StOut;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (abort) begin
          state_d = StFin;
        end else if (lat_cnt_q == 2'd0) begin
          state_d = StOut;
        end
      end
      StOut: begin
        if (abort) begin
          state_d = StFin;
        end else if (beat_hs) begin
          state_d = (remaining_q == CNT_WIDTH'(1)) ? StFin : StIssue;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr_q  <= '0;
      remaining_q <= '0;
      lat_cnt_q   <= '0;
      dbg_addr_q  <= '0;
      m_data_q    <= '0;
      m_addr_q    <= '0;
      m_last_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if ((state_q == StIdle) && start) begin
        cur_addr_q  <= start_addr;
        remaining_q <= word_count;
        err_q       <= start_bad;
      end
      if (state_q == StIssue) begin
        dbg_addr_q <= cur_addr_q;
        lat_cnt_q  <= LatInit;
      end
      if ((state_q == StWait) && (lat_cnt_q != 2'd0)) begin
        lat_cnt_q <= lat_cnt_q - 2'd1;
      end
      if (capture) begin
        m_data_q <= debug_data;
        m_addr_q <= cur_addr_q;
        m_last_q <= (remaining_q == CNT_WIDTH'(1));
      end
      // An abort coinciding with m_ready still consumes the beat.
      if (beat_hs) begin
        remaining_q <= remaining_q - CNT_WIDTH'(1);
        cur_addr_q  <= cur_addr_q + ADDR_WIDTH'(WORD_BYTES);
      end
    end
  end

  always_comb begin
    debug_addr = (state_q == StIssue) ? cur_addr_q : dbg_addr_q;
    m_valid    = (state_q == StOut);
    m_data     = m_data_q;
    m_addr     = m_addr_q;
    m_last     = m_last_q;
    busy       = (state_q != StIdle);
    done       = (state_q == StFin);
    err        = err_q;
  end

endmodule

// File: tb/tb_bram_dump.sv
// Scoreboard bench for bram_dump: three instances (read latency 0, 1, 2) over a
// shared behavioural memory; stimulus pushes expected beats, monitors pop them.
module tb_bram_dump;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, start0, start2;
  logic [9:0]  start_addr;
  logic [8:0]  word_count;
  logic        abort;
  logic        m_ready;
  logic [31:0] mem [256];

  logic [9:0]  daddr0, daddr1, daddr2;
  logic [31:0] ddata0, ddata1, ddata2, pipe2;
  logic        v0, v1, v2, l0, l1, l2;
  logic [31:0] md0, d1, md2;
  logic [9:0]  ma0, a1, ma2;
  logic        busy0, busy1, busy2, done0, done1, done2, err0, err1, err2;

  int    n_cmp = 0, n_fail = 0, cyc = 0;
  int    hs1 = 0, ndone1 = 0, ndone0 = 0, ndone2 = 0;
  beat_t q0[$], q1[$], q2[$];
  int    hs0c[$], hs2c[$];

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  // Behavioural read ports at latency 0, 1 and 2.
  assign ddata0 = mem[daddr0[9:2]];
  always_ff @(posedge clk) ddata1 <= mem[daddr1[9:2]];
  always_ff @(posedge clk) begin
    pipe2  <= mem[daddr2[9:2]];
    ddata2 <= pipe2;
  end

  bram_dump #(.RD_LATENCY(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .word_count(word_count),
    .abort(abort), .debug_addr(daddr1), .debug_data(ddata1), .m_valid(v1), .m_ready(m_ready),
    .m_data(d1), .m_addr(a1), .m_last(l1), .busy(busy1), .done(done1), .err(err1)
  );

  bram_dump #(.RD_LATENCY(0)) u_dut_l0 (
    .clk(clk), .rst(rst), .start(start0), .start_addr(start_addr), .word_count(word_count),
    .abort(1'b0), .debug_addr(daddr0), .debug_data(ddata0), .m_valid(v0), .m_ready(1'b1),
    .m_data(md0), .m_addr(ma0), .m_last(l0), .busy(busy0), .done(done0), .err(err0)
  );

  bram_dump #(.RD_LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst(rst), .start(start2), .start_addr(start_addr), .word_count(word_count),
    .abort(1'b0), .debug_addr(daddr2), .debug_data(ddata2), .m_valid(v2), .m_ready(1'b1),
    .m_data(md2), .m_addr(ma2), .m_last(l2), .busy(busy2), .done(done2), .err(err2)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] got);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got %0h expected no beat", name, got);
  endtask

  // Main-instance monitor: scoreboard pop plus protocol checks.
  initial begin : mon_main
    logic  pv, pr, pab, prst, phs, pdone;
    beat_t pbeat, got, e;
    pv = 0; pr = 0; pab = 0; prst = 1; phs = 0; pdone = 0; pbeat = '0;
    forever begin
      @(negedge clk);
      got = {a1, d1, l1};
      if (!rst && !prst) begin
        if (pv && !pr && !pab) begin
          check("stall_valid_held", 64'(v1), 64'(1));
          check("stall_beat_held", 64'(got), 64'(pbeat));
        end
        if (phs) check("valid_gap_after_beat", 64'(v1), 64'(0));
        if (pdone) begin
          check("done_one_cycle", 64'(done1), 64'(0));
          check("busy_low_after_done", 64'(busy1), 64'(0));
        end
        if (v1 && m_ready) begin
          hs1++;
          if (q1.size() == 0) fail_now("unexpected_beat", 64'(got));
          else begin
            e = q1.pop_front();
            check("beat", 64'(got), 64'(e));
          end
        end
        if (done1) ndone1++;
      end
      pv = v1; pr = m_ready; pab = abort; prst = rst; phs = v1 && m_ready;
      pdone = done1; pbeat = got;
    end
  end

  initial begin : mon_lat
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (v0) begin
          hs0c.push_back(cyc);
          if (q0.size() == 0) fail_now("lat0_unexpected_beat", 64'({ma0, md0, l0}));
          else begin
            e = q0.pop_front();
            check("lat0_beat", 64'({ma0, md0, l0}), 64'(e));
          end
        end
        if (v2) begin
          hs2c.push_back(cyc);
          if (q2.size() == 0) fail_now("lat2_unexpected_beat", 64'({ma2, md2, l2}));
          else begin
            e = q2.pop_front();
            check("lat2_beat", 64'({ma2, md2, l2}), 64'(e));
          end
        end
        if (done0) ndone0++;
        if (done2) ndone2++;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_start(input logic [9:0] a, input logic [8:0] n);
    start_addr = a;
    word_count = n;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy1 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_idle_in_time"}, 64'(k < 200), 64'(1));
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!v1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_valid_in_time"}, 64'(v1), 64'(1));
  endtask

  task automatic end_check(input string tag, input int d0, input int exp_done,
                           input logic exp_err);
    check({tag, "_done_count"}, 64'(ndone1 - d0), 64'(exp_done));
    check({tag, "_queue_drained"}, 64'(q1.size()), 64'(0));
    check({tag, "_err"}, 64'(err1), 64'(exp_err));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_debug_addr"}, 64'(daddr1), 64'(0));
    check({tag, "_m_valid"}, 64'(v1), 64'(0));
    check({tag, "_m_data"}, 64'(d1), 64'(0));
    check({tag, "_m_addr"}, 64'(a1), 64'(0));
    check({tag, "_m_last"}, 64'(l1), 64'(0));
    check({tag, "_busy"}, 64'(busy1), 64'(0));
    check({tag, "_done"}, 64'(done1), 64'(0));
    check({tag, "_err"}, 64'(err1), 64'(0));
  endtask

  initial begin : stim
    int d0, h0, k;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA5A50000 | 32'(i);
    mem[0]   = 32'h00000003;
    mem[1]   = 32'h00000001;
    mem[255] = 32'hCAFEF00D;
    rst = 1'b1; start = 0; start0 = 0; start2 = 0; abort = 0; m_ready = 1'b1;
    start_addr = '0; word_count = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Two-word dump, ready tied high.
    d0 = ndone1;
    q1.push_back({10'h000, 32'h00000003, 1'b0});
    q1.push_back({10'h004, 32'h00000001, 1'b1});
    do_start(10'h000, 9'd2);
    wait_idle("dump2");
    end_check("dump2", d0, 1, 1'b0);

    // Same dump with downstream stalling beat 1 for five cycles.
    d0 = ndone1;
    m_ready = 1'b0;
    q1.push_back({10'h000, 32'h00000003, 1'b0});
    q1.push_back({10'h004, 32'h00000001, 1'b1});
    do_start(10'h000, 9'd2);
    wait_valid("stall");
    repeat (5) begin @(posedge clk); #1; end
    check("stall_data_after_5", 64'(d1), 64'h3);
    m_ready = 1'b1;
    wait_idle("stall");
    end_check("stall", d0, 1, 1'b0);

    // Misaligned start, then a good start clears err.
    d0 = ndone1;
    do_start(10'h002, 9'd1);
    wait_idle("misalign");
    end_check("misalign", d0, 1, 1'b1);
    d0 = ndone1;
    q1.push_back({10'h000, 32'h00000003, 1'b1});
    do_start(10'h000, 9'd1);
    check("err_cleared_on_start", 64'(err1), 64'(0));
    wait_idle("recover");
    end_check("recover", d0, 1, 1'b0);

    // Range overflow at the top of memory, then the exact last word.
    d0 = ndone1;
    do_start(10'h3FC, 9'd2);
    wait_idle("overflow");
    end_check("overflow", d0, 1, 1'b1);
    d0 = ndone1;
    q1.push_back({10'h3FC, 32'hCAFEF00D, 1'b1});
    do_start(10'h3FC, 9'd1);
    wait_idle("topword");
    end_check("topword", d0, 1, 1'b0);

    // Zero-length dump.
    d0 = ndone1;
    h0 = hs1;
    do_start(10'h010, 9'd0);
    wait_idle("zero");
    end_check("zero", d0, 1, 1'b0);
    check("zero_no_beats", 64'(hs1 - h0), 64'(0));

    // Abort while beat 2 of 4 is presented with ready high: beat 2 still counts.
    d0 = ndone1;
    h0 = hs1;
    q1.push_back({10'h000, 32'h00000003, 1'b0});
    q1.push_back({10'h004, 32'h00000001, 1'b0});
    do_start(10'h000, 9'd4);
    k = 0;
    while (!(v1 && hs1 == h0 + 1) && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("abort_reached_beat2", 64'(v1 && hs1 == h0 + 1), 64'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid_dropped", 64'(v1), 64'(0));
    wait_idle("abort");
    end_check("abort", d0, 1, 1'b0);
    check("abort_beats_accepted", 64'(hs1 - h0), 64'(2));

    // Reset in the middle of a stalled dump: everything back to zero, no done.
    d0 = ndone1;
    m_ready = 1'b0;
    do_start(10'h000, 9'd4);
    wait_valid("midrst");
    check("midrst_data_before", 64'(d1), 64'h3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_zero("midrst");
    repeat (3) begin @(posedge clk); #1; end
    check("midrst_no_done", 64'(ndone1 - d0), 64'(0));
    m_ready = 1'b1;

    // Two-word dump on the latency-0 and latency-2 instances.
    q0.push_back({10'h000, 32'h00000003, 1'b0});
    q0.push_back({10'h004, 32'h00000001, 1'b1});
    q2.push_back({10'h000, 32'h00000003, 1'b0});
    q2.push_back({10'h004, 32'h00000001, 1'b1});
    start_addr = 10'h000;
    word_count = 9'd2;
    start0 = 1'b1;
    start2 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    k = 0;
    while ((busy0 || busy2) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("lat_idle_in_time", 64'(k < 100), 64'(1));
    check("lat0_queue_drained", 64'(q0.size()), 64'(0));
    check("lat2_queue_drained", 64'(q2.size()), 64'(0));
    check("lat0_beats", 64'(hs0c.size()), 64'(2));
    check("lat2_beats", 64'(hs2c.size()), 64'(2));
    if (hs0c.size() == 2) check("lat0_spacing", 64'(hs0c[1] - hs0c[0]), 64'(2));
    if (hs2c.size() == 2) check("lat2_spacing", 64'(hs2c[1] - hs2c[0]), 64'(4));
    check("lat0_done", 64'(ndone0), 64'(1));
    check("lat2_done", 64'(ndone2), 64'(1));
    check("lat_err", 64'({err0, err2}), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_dump.md
Name: bram_dump

Overview:
- Read-side counterpart of the bench/loader path that writes the instruction and data BRAMs (bram32) through their write port.
- Walks a word range through the bram32 debug read port (debug_addr/debug_data) and streams each word out on a valid/ready interface. Each beat carries the word's byte address.
- Sits beside the data BRAM. Used for post-run memory readback by benches and, later, by the board-level debug link.
- Never writes memory and never touches the CPU read port.

Parameters:
- ADDR_WIDTH, 10, byte-address width of the BRAM debug port.
- DATA_WIDTH, 32, word width.
- CNT_WIDTH, 9, width of word_count; max 256 words = full 1 KiB BRAM.
- RD_LATENCY, 1, cycles from debug_addr to valid debug_data. Legal values: 0, 1, 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- start_addr  in  ADDR_WIDTH  first byte address; must be word aligned.
- word_count  in  CNT_WIDTH  number of words to dump.
- abort  in  1  cancel the dump in progress.
- debug_addr  out  ADDR_WIDTH  address to bram32 debug port.
- debug_data  in  DATA_WIDTH  data from bram32 debug port.
- m_valid  out  1  stream word valid.
- m_ready  in  1  downstream accepts word.
- m_data  out  DATA_WIDTH  word read.
- m_addr  out  ADDR_WIDTH  byte address of m_data.
- m_last  out  1  high on the final beat.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on completion, abort or error.
- err  out  1  sticky error flag; cleared by the next accepted start or by rst.

Behaviour:
- Reset: state=IDLE. debug_addr=0, m_valid=0, m_data=0, m_addr=0, m_last=0, busy=0, done=0, err=0.
- FSM states: IDLE, ISSUE, WAIT, OUT, FIN.
- IDLE + start: latch cur_addr=start_addr and remaining=word_count, clear err. Next state:
  - FIN with err=1 if start_addr[1:0]!=0.
  - FIN with err=1 if start_addr + 4*word_count > 2^ADDR_WIDTH (compute in ADDR_WIDTH+CNT_WIDTH+2 bits, no wrap).
  - FIN with err=0 if word_count==0; no beats are emitted.
  - ISSUE otherwise.
- ISSUE: drive debug_addr=cur_addr.
  - RD_LATENCY=0: capture debug_data the same cycle and go to OUT.
  - RD_LATENCY>0: go to WAIT with lat_cnt=RD_LATENCY-1.
- WAIT: hold debug_addr. When lat_cnt==0, capture debug_data into m_data, m_addr=cur_addr, m_last=(remaining==1), and go to OUT. Otherwise decrement lat_cnt.
- OUT: m_valid=1, with m_data/m_addr/m_last stable until the handshake.
  - On m_valid&&m_ready: remaining-=1, cur_addr+=4.
  - If remaining was 1, go to FIN; otherwise go to ISSUE.
  - m_valid drops for at least the next cycle after every beat.
  - Throughput is one word per RD_LATENCY+2 cycles; no prefetch.
- FIN: done=1 for exactly one cycle, m_valid=0, then IDLE. busy is low from IDLE onward.
- abort in any non-IDLE state: next state FIN, m_valid=0 next cycle, err unchanged. This is the only case where valid may fall without a handshake.
- Simultaneous events:
  - abort and m_ready on the same OUT cycle: the beat counts as accepted, then FIN.
  - start outside IDLE is ignored.
  - start and abort together in IDLE: abort is ignored and start is taken.
- rst mid-dump: immediate return to reset values at the clock edge; no done pulse.
- debug_addr holds its last value in IDLE and FIN.

Decomposition:
- rv32i_params.vh gets: DUMP_IDLE/ISSUE/WAIT/OUT/FIN state encodings (3-bit localparam-style defines) and WORD_BYTES=4. Reuse DATA_WIDTH.
- No sub-module. The optional range check may live as a function inside the module. Target is about 150–220 lines.

Test Plan:
- Data BRAM is preloaded with 0x00000003 at 0x000 and 0x00000001 at 0x004, with m_ready tied high.
  - start, start_addr=0, word_count=2 gives 2 beats: (0x000, 0x00000003, last=0) then (0x004, 0x00000001, last=1).
  - done pulses once after the last beat, and busy falls with it.
- Same dump with m_ready low for 5 cycles during beat 1: m_valid stays high, m_data stays 0x00000003 until accepted, and the sequence is unchanged.
- start_addr=0x002, word_count=1: no beats, err=1, one done pulse 2 cycles after start. The next valid start clears err.
- start_addr=0x3FC, word_count=2: err=1, no beats. start_addr=0x3FC, word_count=1: one beat with m_addr=0x3FC, last=1, err=0.
- word_count=0: done pulses with no m_valid, err=0.
- 4-word dump:
  - abort asserted while beat 2 is presented: m_valid drops the next cycle, done pulses once, and at most 2 beats are accepted.
  - rst mid-dump instead: all outputs return to 0 and there is no done.
- Repeat scenario 1 with RD_LATENCY=0 and with RD_LATENCY=2: same data, with beat spacing of 2 and 4 cycles respectively.
